conv8_sched: RTL and testbench
==============================

Name: conv8_sched

Overview:
- Sequencer and accumulator for the 8-row, 3-filter-row convolution core (11 PE_ROW8 instances, 4 row sums out).
- Per output tile it:
  - streams ROW_LEN column reads per input channel,
  - drives the core enable aligned to read data,
  - waits out the PE pipeline,
  - accumulates the core's four sums across channels,
  - hands the four results downstream over a valid/ready handshake.
- Sits between the row/filter buffers and the output writeback.

Parameters:
- DATA_W, conv8_width (definition package): core element width.
- ROW_LEN, 8: columns streamed per channel pass.
- PE_LAT, 2: cycles from the last core_en to stable core sums.
- ACC_W, 2*DATA_W+8: cross-channel accumulator width.
- CNT_W, 8: width of tile/channel counters and configuration.

Ports:
- clk, in, 1: clock.
- rstn, in, 1: synchronous active-low reset.
- start, in, 1: begin a job; sampled only in IDLE.
- cfg_num_tiles, in, CNT_W: tiles in the job.
- cfg_num_ch, in, CNT_W: input channels per tile.
- rd_en, out, 1: buffer read strobe; buffer data returns the next cycle.
- rd_tile, out, CNT_W: current tile index.
- rd_ch, out, CNT_W: current channel index.
- rd_col, out, $clog2(ROW_LEN): current column index.
- core_en, out, 1: enable to the convolution core.
- core_clr, out, 1: clears PE partial sums.
- core_sum1..core_sum4, in, 2*DATA_W each: core row sums.
- o_valid, out, 1: result valid.
- o_ready, in, 1: downstream accept.
- o_sum1..o_sum4, out, ACC_W each: accumulated tile results.
- busy, out, 1: job in progress.
- done, out, 1: one-cycle pulse at job end.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low on rstn.
- Reset values: every output 0, state IDLE, all counters 0.
- rstn low at any point, including mid-job or with o_valid high, aborts the job. Accumulators clear, and no done pulse is issued for the aborted job.
- State machine: IDLE, STREAM, WAIT, ACC, OUT, FIN.
- IDLE:
  - start=1 with both cfg values non-zero: latch cfg, tile=ch=0, core_clr=1 for this cycle, go STREAM.
  - start=1 with either cfg value zero: go FIN, no reads.
  - busy=0 only in IDLE.
- STREAM:
  - rd_en=1 for ROW_LEN cycles with rd_col=0..ROW_LEN-1; rd_tile and rd_ch hold current indices.
  - core_en is rd_en registered by one cycle, so it is high for exactly ROW_LEN cycles, aligned with read data.
  - After the col=ROW_LEN-1 cycle, go WAIT.
- WAIT: hold for PE_LAT+1 cycles (last core_en plus pipeline), rd_en=0, then go ACC.
- ACC (1 cycle):
  - ch==0: acc_k = zero-extended core_sumk.
  - otherwise: acc_k = acc_k + core_sumk.
  - Arithmetic is unsigned, modulo 2^ACC_W (wraps, no saturation).
  - core_clr=1 in this cycle.
  - If ch<num_ch-1: ch++, go STREAM. Else go OUT.
- OUT:
  - o_valid=1; o_sum1..4 = acc1..4, held stable until o_ready=1.
  - Transfer occurs when o_valid && o_ready. On transfer o_valid drops the next cycle, then:
    - tile<num_tiles-1: tile++, ch=0, go STREAM.
    - else: go FIN.
  - o_ready high before o_valid has no effect.
- FIN: done=1 for one cycle, go IDLE. start in FIN is ignored.
- start while busy is ignored. cfg changes while busy are ignored (latched copies used).
- Timing (defaults, start accepted at cycle 0, 1 channel, 1 tile):
  - rd_en cycles 1-8, core_en cycles 2-9.
  - WAIT cycles 9-11, ACC cycle 12.
  - o_valid from cycle 13; with o_ready=1, FIN/done at cycle 14.
- Per-channel cost: ROW_LEN+PE_LAT+2 cycles.
- Sum-to-output mapping fixed: core_sumk feeds acck feeds o_sumk, k=1..4.

Decomposition:
- definition package holds:
  - conv8_width;
  - state enum sched_state_t {IDLE, STREAM, WAIT, ACC, OUT, FIN};
  - constants CONV8_ROW_LEN and CONV8_PE_LAT.
- One natural sub-module: conv8_acc4. It holds the four ACC_W accumulators with load/add/hold control and is instantiated once.
- The FSM and counters stay in conv8_sched.

Test Plan:
- Single tile, single channel: cfg 1/1; core_sum1..4 = 10,20,30,40 held constant.
  - rd_en cycles 1-8, core_en 2-9, o_valid at 13.
  - o_sum = 10,20,30,40; done at 14 with o_ready tied 1.
- Channel accumulation: cfg 1/3, core_sum1 = 100 each pass.
  - Three STREAM bursts of 8, rd_ch = 0,1,2.
  - o_sum1 = 300; core_clr pulses at start and at each ACC.
- Backpressure: cfg 2/1, o_ready low for 5 cycles after o_valid.
  - o_valid and o_sum stay stable; tile 1 STREAM starts the cycle after the handshake.
  - Exactly 2 transfers, one done.
- Zero config and start-while-busy:
  - cfg_num_ch=0: done the cycle after start, rd_en never asserted.
  - start pulsed mid-job: no restart, counters unchanged.
- Wrap: DATA_W=8, cfg 1/2, core_sum1 = 65535 (2^(2*DATA_W)-1) both passes.
  - o_sum1 = 131070 (no wrap at ACC_W=24).
  - Forced ACC_W=16 build gives 65534.
- Reset mid-operation: rstn low during WAIT of channel 1.
  - Next cycle all outputs 0, state IDLE.
  - A new start runs a full job with acc starting from 0.

Source files
------------

// File: rtl/conv8_sched_pkg.sv
// Shared definitions for the 8-row convolution scheduler: element width,
// streaming geometry, PE pipeline latency and the scheduler state encoding.
package conv8_sched_pkg;

  localparam int conv8_width   = 8;
  localparam int CONV8_ROW_LEN = 8;
  localparam int CONV8_PE_LAT  = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STREAM = 3'd1,
    WAIT   = 3'd2,
    ACC    = 3'd3,
    OUT    = 3'd4,
    FIN    = 3'd5
  } sched_state_t;

endpackage

// File: rtl/conv8_acc4.sv
// Four cross-channel accumulators. load replaces the running value with the
// zero-extended input (first channel); add sums modulo 2^ACC_W.
module conv8_acc4
  import conv8_sched_pkg::*;
#(
  parameter int IN_W  = 2 * conv8_width,
  parameter int ACC_W = 2 * conv8_width + 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             add,
  input  logic [IN_W-1:0]  in1,
  input  logic [IN_W-1:0]  in2,
  input  logic [IN_W-1:0]  in3,
  input  logic [IN_W-1:0]  in4,
  output logic [ACC_W-1:0] acc1,
  output logic [ACC_W-1:0] acc2,
  output logic [ACC_W-1:0] acc3,
  output logic [ACC_W-1:0] acc4
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc1 <= '0;
      acc2 <= '0;
      acc3 <= '0;
      acc4 <= '0;
    end else if (load) begin
      acc1 <= ACC_W'(in1);
      acc2 <= ACC_W'(in2);
      acc3 <= ACC_W'(in3);
      acc4 <= ACC_W'(in4);
    end else if (add) begin
      acc1 <= acc1 + ACC_W'(in1);
      acc2 <= acc2 + ACC_W'(in2);
      acc3 <= acc3 + ACC_W'(in3);
      acc4 <= acc4 + ACC_W'(in4);
    end
  end

endmodule

// File: rtl/conv8_sched.sv
// Tile/channel sequencer for the conv8 core: streams column reads, waits out
// the PE pipeline, accumulates row sums across channels and emits per tile.
module conv8_sched
  import conv8_sched_pkg::*;
#(
  parameter int DATA_W  = conv8_width,
  parameter int ROW_LEN = CONV8_ROW_LEN,
  parameter int PE_LAT  = CONV8_PE_LAT,
  parameter int ACC_W   = 2 * DATA_W + 8,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [CNT_W-1:0]           cfg_num_tiles,
  input  logic [CNT_W-1:0]           cfg_num_ch,
  output logic                       rd_en,
  output logic [CNT_W-1:0]           rd_tile,
  output logic [CNT_W-1:0]           rd_ch,
  output logic [$clog2(ROW_LEN)-1:0] rd_col,
  output logic                       core_en,
  output logic                       core_clr,
  input  logic [2*DATA_W-1:0]        core_sum1,
  input  logic [2*DATA_W-1:0]        core_sum2,
  input  logic [2*DATA_W-1:0]        core_sum3,
  input  logic [2*DATA_W-1:0]        core_sum4,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [ACC_W-1:0]           o_sum1,
  output logic [ACC_W-1:0]           o_sum2,
  output logic [ACC_W-1:0]           o_sum3,
  output logic [ACC_W-1:0]           o_sum4,
  output logic                       busy,
  output logic                       done,
  output logic [2:0]                 state_dbg
);

  localparam int COL_W  = $clog2(ROW_LEN);
  localparam int WAIT_W = $clog2(PE_LAT + 2);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(ROW_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PE_LAT);

  // Output handshake: a result transfers in any cycle where o_valid && o_ready;
  // o_valid stays high with o_sum stable until then, and ready alone does nothing.

  sched_state_t state, state_d;

  logic [CNT_W-1:0]  num_tiles_q, num_ch_q, tile_q, ch_q;
  logic [COL_W-1:0]  col_q;
  logic [WAIT_W-1:0] wait_q;
  logic              core_en_q;
  logic              cfg_ok, last_ch, last_tile;
  logic              acc_load, acc_add;

  assign cfg_ok    = (cfg_num_tiles != '0) && (cfg_num_ch != '0);
  assign last_ch   = (ch_q == num_ch_q - CNT_W'(1));
  assign last_tile = (tile_q == num_tiles_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d  = state;
    rd_en    = 1'b0;
    core_clr = 1'b0;
    o_valid  = 1'b0;
    done     = 1'b0;
    acc_load = 1'b0;
    acc_add  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_d  = STREAM;
            core_clr = 1'b1;
          end else begin
            state_d = FIN;
          end
        end
      end
      STREAM: begin
        rd_en = 1'b1;
        if (col_q == COL_LAST) state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == WAIT_LAST) state_d = ACC;
      end
      ACC: begin
        core_clr = 1'b1;
        acc_load = (ch_q == '0);
        acc_add  = (ch_q != '0);
        state_d  = last_ch ? OUT : STREAM;
      end
      OUT: begin
        o_valid = 1'b1;
        if (o_ready) state_d = last_tile ? FIN : STREAM;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters and latched configuration; cfg is only sampled when a job is accepted.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      num_tiles_q <= '0;
      num_ch_q    <= '0;
      tile_q      <= '0;
      ch_q        <= '0;
      col_q       <= '0;
      wait_q      <= '0;
      core_en_q   <= 1'b0;
    end else begin
      core_en_q <= rd_en;
      case (state)
        IDLE: begin
          if (start && cfg_ok) begin
            num_tiles_q <= cfg_num_tiles;
            num_ch_q    <= cfg_num_ch;
            tile_q      <= '0;
            ch_q        <= '0;
            col_q       <= '0;
          end
        end
        STREAM: begin
          col_q  <= (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
          wait_q <= '0;
        end
        WAIT: wait_q <= wait_q + WAIT_W'(1);
        ACC: begin
          if (!last_ch) ch_q <= ch_q + CNT_W'(1);
        end
        OUT: begin
          if (o_ready && !last_tile) begin
            tile_q <= tile_q + CNT_W'(1);
            ch_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  conv8_acc4 #(
    .IN_W  (2 * DATA_W),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk  (clk),
    .rstn (rstn),
    .load (acc_load),
    .add  (acc_add),
    .in1  (core_sum1),
    .in2  (core_sum2),
    .in3  (core_sum3),
    .in4  (core_sum4),
    .acc1 (o_sum1),
    .acc2 (o_sum2),
    .acc3 (o_sum3),
    .acc4 (o_sum4)
  );

  assign rd_tile   = tile_q;
  assign rd_ch     = ch_q;
  assign rd_col    = col_q;
  assign core_en   = core_en_q;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_conv8_sched.sv
// Directed bench for conv8_sched: cycle-indexed expectations against the
// documented timeline, plus a 16-bit accumulator build for the wrap case.
module tb_conv8_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cfg_num_tiles = '0;
  logic [7:0]  cfg_num_ch = '0;
  logic [15:0] core_sum1 = '0, core_sum2 = '0, core_sum3 = '0, core_sum4 = '0;
  logic        o_ready = 1'b0;

  logic        rd_en, core_en, core_clr, o_valid, busy, done;
  logic [7:0]  rd_tile, rd_ch;
  logic [2:0]  rd_col, state_dbg;
  logic [23:0] o_sum1, o_sum2, o_sum3, o_sum4;

  logic        w_rd_en, w_core_en, w_core_clr, w_o_valid, w_busy, w_done;
  logic [7:0]  w_rd_tile, w_rd_ch;
  logic [2:0]  w_rd_col, w_state_dbg;
  logic [15:0] w_sum1, w_sum2, w_sum3, w_sum4;

  int n_cmp = 0;
  int n_err = 0;
  int xfers, dones;

  always #5 clk = ~clk;

  conv8_sched dut (
    .clk(clk), .rstn(rstn), .start(start),
    .cfg_num_tiles(cfg_num_tiles), .cfg_num_ch(cfg_num_ch),
    .rd_en(rd_en), .rd_tile(rd_tile), .rd_ch(rd_ch), .rd_col(rd_col),
    .core_en(core_en), .core_clr(core_clr),
    .core_sum1(core_sum1), .core_sum2(core_sum2),
    .core_sum3(core_sum3), .core_sum4(core_sum4),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_sum1(o_sum1), .o_sum2(o_sum2), .o_sum3(o_sum3), .o_sum4(o_sum4),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  conv8_sched #(.ACC_W(16)) dut16 (
    .clk(clk), .rstn(rstn), .start(start),
    .cfg_num_tiles(cfg_num_tiles), .cfg_num_ch(cfg_num_ch),
    .rd_en(w_rd_en), .rd_tile(w_rd_tile), .rd_ch(w_rd_ch), .rd_col(w_rd_col),
    .core_en(w_core_en), .core_clr(w_core_clr),
    .core_sum1(core_sum1), .core_sum2(core_sum2),
    .core_sum3(core_sum3), .core_sum4(core_sum4),
    .o_valid(w_o_valid), .o_ready(o_ready),
    .o_sum1(w_sum1), .o_sum2(w_sum2), .o_sum3(w_sum3), .o_sum4(w_sum4),
    .busy(w_busy), .done(w_done), .state_dbg(w_state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    chk1({pfx, "_rd_en"}, rd_en, 1'b0);
    chk1({pfx, "_core_en"}, core_en, 1'b0);
    chk1({pfx, "_core_clr"}, core_clr, 1'b0);
    chk1({pfx, "_o_valid"}, o_valid, 1'b0);
    chk1({pfx, "_busy"}, busy, 1'b0);
    chk1({pfx, "_done"}, done, 1'b0);
    chk({pfx, "_rd_tile"}, 32'(rd_tile), 32'd0);
    chk({pfx, "_rd_ch"}, 32'(rd_ch), 32'd0);
    chk({pfx, "_rd_col"}, 32'(rd_col), 32'd0);
    chk({pfx, "_o_sum1"}, 32'(o_sum1), 32'd0);
    chk({pfx, "_o_sum2"}, 32'(o_sum2), 32'd0);
    chk({pfx, "_o_sum3"}, 32'(o_sum3), 32'd0);
    chk({pfx, "_o_sum4"}, 32'(o_sum4), 32'd0);
    chk({pfx, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  // Each loop iteration: drive inputs for cycle c just after posedge, check at negedge.
  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;

    // Single tile, single channel
    core_sum1 = 16'd10; core_sum2 = 16'd20; core_sum3 = 16'd30; core_sum4 = 16'd40;
    o_ready = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      start = (c == 0);
      cfg_num_tiles = 8'd1; cfg_num_ch = 8'd1;
      @(negedge clk);
      chk1("t1_rd_en", rd_en, c >= 1 && c <= 8);
      chk1("t1_core_en", core_en, c >= 2 && c <= 9);
      chk1("t1_core_clr", core_clr, c == 0 || c == 12);
      chk1("t1_o_valid", o_valid, c == 13);
      chk1("t1_done", done, c == 14);
      chk1("t1_busy", busy, c >= 1 && c <= 14);
      if (c >= 1 && c <= 8) chk("t1_rd_col", 32'(rd_col), 32'(c - 1));
      if (c == 13) begin
        chk("t1_o_sum1", 32'(o_sum1), 32'd10);
        chk("t1_o_sum2", 32'(o_sum2), 32'd20);
        chk("t1_o_sum3", 32'(o_sum3), 32'd30);
        chk("t1_o_sum4", 32'(o_sum4), 32'd40);
      end
      @(posedge clk); #1;
    end

    // Channel accumulation over 3 channels; start and cfg changes mid-job are ignored
    core_sum1 = 16'd100; core_sum2 = 16'd1; core_sum3 = 16'd2; core_sum4 = 16'd3;
    for (int c = 0; c <= 40; c++) begin
      logic exp_rd;
      start = (c == 0) || (c == 20);
      cfg_num_tiles = (c == 0) ? 8'd1 : 8'd9;
      cfg_num_ch    = (c == 0) ? 8'd3 : 8'd9;
      exp_rd = (c >= 1) && (c <= 32) && (((c - 1) % 12) < 8);
      @(negedge clk);
      chk1("ch_rd_en", rd_en, exp_rd);
      if (exp_rd) begin
        chk("ch_rd_ch", 32'(rd_ch), 32'((c - 1) / 12));
        chk("ch_rd_col", 32'(rd_col), 32'((c - 1) % 12));
      end
      chk1("ch_core_clr", core_clr, (c % 12 == 0) && c <= 36);
      chk1("ch_o_valid", o_valid, c == 37);
      chk1("ch_done", done, c == 38);
      chk1("ch_busy", busy, c >= 1 && c <= 38);
      if (c == 37) begin
        chk("ch_o_sum1", 32'(o_sum1), 32'd300);
        chk("ch_o_sum2", 32'(o_sum2), 32'd3);
        chk("ch_o_sum3", 32'(o_sum3), 32'd6);
        chk("ch_o_sum4", 32'(o_sum4), 32'd9);
      end
      @(posedge clk); #1;
    end

    // Backpressure: 2 tiles, ready withheld for 5 cycles of tile 0 valid
    xfers = 0; dones = 0;
    core_sum1 = 16'd5; core_sum2 = 16'd6; core_sum3 = 16'd7; core_sum4 = 16'd8;
    for (int c = 0; c <= 34; c++) begin
      start = (c == 0);
      cfg_num_tiles = 8'd2; cfg_num_ch = 8'd1;
      o_ready = (c >= 18);
      if (c == 19) begin
        core_sum1 = 16'd1; core_sum2 = 16'd2; core_sum3 = 16'd3; core_sum4 = 16'd4;
      end
      @(negedge clk);
      if (o_valid && o_ready) xfers++;
      if (done) dones++;
      chk1("bp_o_valid", o_valid, (c >= 13 && c <= 18) || c == 31);
      chk1("bp_done", done, c == 32);
      if (c >= 13 && c <= 18) begin
        chk("bp_hold_sum1", 32'(o_sum1), 32'd5);
        chk("bp_hold_sum4", 32'(o_sum4), 32'd8);
      end
      if (c == 1) chk("bp_rd_tile0", 32'(rd_tile), 32'd0);
      if (c == 19) begin
        chk1("bp_t1_rd_en", rd_en, 1'b1);
        chk("bp_t1_rd_tile", 32'(rd_tile), 32'd1);
        chk("bp_t1_rd_col", 32'(rd_col), 32'd0);
      end
      if (c == 31) begin
        chk("bp_t1_sum1", 32'(o_sum1), 32'd1);
        chk("bp_t1_sum2", 32'(o_sum2), 32'd2);
        chk("bp_t1_sum3", 32'(o_sum3), 32'd3);
        chk("bp_t1_sum4", 32'(o_sum4), 32'd4);
      end
      @(posedge clk); #1;
    end
    chk("bp_xfers", 32'(xfers), 32'd2);
    chk("bp_dones", 32'(dones), 32'd1);

    // Zero channel configuration
    for (int c = 0; c <= 3; c++) begin
      start = (c == 0);
      cfg_num_tiles = 8'd1; cfg_num_ch = 8'd0;
      @(negedge clk);
      chk1("zc_rd_en", rd_en, 1'b0);
      chk1("zc_core_clr", core_clr, 1'b0);
      chk1("zc_done", done, c == 1);
      chk1("zc_busy", busy, c == 1);
      @(posedge clk); #1;
    end

    // Wrap check: two passes of 65535, 24-bit and 16-bit accumulator builds
    core_sum1 = 16'hFFFF; core_sum2 = '0; core_sum3 = '0; core_sum4 = '0;
    for (int c = 0; c <= 27; c++) begin
      start = (c == 0);
      cfg_num_tiles = 8'd1; cfg_num_ch = 8'd2;
      @(negedge clk);
      chk1("wr_o_valid", o_valid, c == 25);
      chk1("wr16_o_valid", w_o_valid, c == 25);
      chk1("wr_done", done, c == 26);
      if (c == 25) begin
        chk("wr_o_sum1", 32'(o_sum1), 32'd131070);
        chk("wr16_o_sum1", 32'(w_sum1), 32'd65534);
      end
      @(posedge clk); #1;
    end

    // Reset during WAIT of channel 1
    core_sum1 = 16'd9; core_sum2 = 16'd8; core_sum3 = 16'd7; core_sum4 = 16'd6;
    for (int c = 0; c <= 28; c++) begin
      start = (c == 0);
      cfg_num_tiles = 8'd1; cfg_num_ch = 8'd2;
      rstn = (c != 22);
      @(negedge clk);
      if (c == 21) begin
        chk("rs_pre_sum1", 32'(o_sum1), 32'd9);
        chk("rs_pre_rd_ch", 32'(rd_ch), 32'd1);
      end
      if (c == 23) check_all_zero("rs_post");
      if (c >= 23) begin
        chk1("rs_no_done", done, 1'b0);
        chk1("rs_idle", busy, 1'b0);
      end
      @(posedge clk); #1;
    end

    // Fresh job after reset
    core_sum1 = 16'd3; core_sum2 = 16'd4; core_sum3 = 16'd5; core_sum4 = 16'd6;
    for (int c = 0; c <= 15; c++) begin
      start = (c == 0);
      cfg_num_tiles = 8'd1; cfg_num_ch = 8'd1;
      @(negedge clk);
      chk1("nj_o_valid", o_valid, c == 13);
      chk1("nj_done", done, c == 14);
      if (c == 13) begin
        chk("nj_o_sum1", 32'(o_sum1), 32'd3);
        chk("nj_o_sum2", 32'(o_sum2), 32'd4);
        chk("nj_o_sum3", 32'(o_sum3), 32'd5);
        chk("nj_o_sum4", 32'(o_sum4), 32'd6);
      end
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
